led_pwm_driver: RTL
===================

// Module: led_pwm_driver
// PURPOSE
//  Downstream consumer of the LED palette pulser. Converts the 8-bit palette values
//  (red/green/blue per color LED, luminance per basic LED) into registered PWM
//  drive bits for the board pins. Values are double-buffered and take effect only
//  at a PWM period boundary, so mid-period updates cause no glitches.
//  Optional phase staggering spreads the LED turn-on edges across the period.
// PARAMETERS
//  parm_color_led_count  4           number of RGB LEDs (C); must be 1,2,4 or 8
//  parm_basic_led_count  4           number of single-color LEDs (B); must be 1,2,4 or 8
//  parm_FCLK             40_000_000  i_clk frequency in Hz
//  parm_pwm_period_hz    1000        PWM periods per second;
//                                    DIV = parm_FCLK/(parm_pwm_period_hz*256) must be >= 1
//  parm_stagger          1           1 = per-LED phase offset; 0 = all LEDs aligned
// PORTS
//  i_clk                    in   1     system clock
//  i_arst_n                 in   1     reset, asynchronous assert, active-low
//  i_color_led_red_value    in   8*C   red duty per LED; LED k = bits [8k+7:8k]
//  i_color_led_green_value  in   8*C   green duty per LED, same packing
//  i_color_led_blue_value   in   8*C   blue duty per LED, same packing
//  i_basic_led_lumin_value  in   8*B   luminance duty per basic LED, same packing
//  o_color_led_red          out  C     PWM drive, red element of LED k at bit k
//  o_color_led_green        out  C     PWM drive, green element
//  o_color_led_blue         out  C     PWM drive, blue element
//  o_basic_led              out  B     PWM drive, basic LED k at bit k
//  o_period_strobe          out  1     one-clock pulse on the cycle the shadow duties load
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-low.
//    While i_arst_n = 0, all of the following are 0 immediately, without waiting
//    for a clock edge: prescaler, PWM counter, every shadow duty, every output,
//    and o_period_strobe.
//  - Prescaler: counts 0..DIV-1. The tick is high on the cycle the count is DIV-1;
//    the count then wraps to 0. With DIV = 1 the tick is high on every cycle.
//  - PWM counter: 8 bits, increments on each tick, and wraps from 255 to 0.
//    One period is 256 ticks.
//  - Period boundary: the cycle where the tick is high and the counter is 255. On it:
//    - every shadow duty register loads its input value;
//    - o_period_strobe is 1 on the following cycle only.
//  - Phase of LED k: ph = (cnt + off_k) mod 256.
//    - off_k = k*(256/C) for color LEDs and k*(256/B) for basic LEDs.
//    - off_k = 0 for all LEDs when parm_stagger = 0.
//    - All three elements of one RGB LED share the same off_k.
//  - Compare: each output register loads (ph < shadow_duty) on every clock, so an
//    output lags the counter by exactly 1 clock.
//  - Width rule: unsigned 8-bit compare. Duty 0 gives an output that is never high.
//    Duty 255 gives 255 high ticks and 1 low tick per period. Duty d gives exactly
//    d high ticks per period.
//  - Latency: an input change is seen on the outputs starting at the first period
//    boundary after the change, plus 1 clock. Changes at any other time are ignored
//    until that boundary.
//  - An input that changes on the boundary cycle itself is captured with its new value.
//  - With staggering, a shadow load takes effect at an arbitrary point in LED k's
//    phase. For that one period LED k's high-time is between old d and new d.
//  - Reset released mid-operation: counting restarts at prescaler 0 and counter 0.
//    Outputs stay 0 until the first period boundary loads the shadows.
// TESTING  (bench: parm_FCLK=2560, parm_pwm_period_hz=10 -> DIV=1)
//  1 Hold reset low with inputs 0xFF, then release -> all outputs stay 0 for
//    256 clocks; o_period_strobe first pulses 257 clocks after release.
//  2 stagger=0, LED0 red=0x80 -> o_color_led_red[0] is high for exactly 128 of each
//    256 clocks, rising 1 clock after counter 0; the other outputs stay 0.
//  3 Red duty 0xFF -> 255 high / 1 low per period. Duty 0x01 -> 1 high per period.
//    Duty 0x00 -> never high.
//  4 Change LED0 red from 0x20 to 0xC0 at counter=100 -> current period keeps 32 high
//    ticks; the next period has 192.
//  5 stagger=1, C=4, all reds 0x40 -> each LED is high for 64 ticks; the four high
//    windows do not overlap and together cover the whole period.
//  6 Pulse i_arst_n low mid-period with no clock edge -> all outputs and the strobe
//    go 0 at once; after release, behaviour matches scenario 1.

Source files
------------

// File: rtl/led_pwm_driver.sv
// -----------------------------------------------------------------------------
// led_pwm_driver
//
// Converts 8-bit palette duties (red/green/blue per RGB LED, luminance per
// basic LED) into registered PWM drive bits for the board pins.
//
// Timing:
//   - A prescaler divides i_clk by DIV = parm_FCLK / (parm_pwm_period_hz*256).
//     Its tick advances an 8-bit PWM counter, so one PWM period is 256 ticks.
//   - Duties are double-buffered. The shadow registers load only on the period
//     boundary (tick high with the counter at 255), so mid-period input changes
//     never glitch the outputs.
//   - o_period_strobe is high for the one clock after the boundary, i.e. the
//     first clock during which the new shadow duties are in force.
//   - Each output register loads (phase < shadow_duty) every clock, so the pins
//     trail the counter by exactly one clock.
//   - With parm_stagger = 1, LED k compares against cnt + k*(256/N) (mod 256).
//     This spreads the turn-on edges across the period. The three elements of an
//     RGB LED share one offset.
//
// Ports:
//   i_clk                    system clock
//   i_arst_n                 asynchronous, active-low reset
//   i_color_led_red_value    8*C  red duty, LED k at [8k+7:8k]
//   i_color_led_green_value  8*C  green duty, same packing
//   i_color_led_blue_value   8*C  blue duty, same packing
//   i_basic_led_lumin_value  8*B  basic LED duty, same packing
//   o_color_led_red          C    red PWM drive, LED k at bit k
//   o_color_led_green        C    green PWM drive
//   o_color_led_blue         C    blue PWM drive
//   o_basic_led              B    basic LED PWM drive
//   o_period_strobe          1    one-clock pulse as the shadow duties take effect
// -----------------------------------------------------------------------------
module led_pwm_driver #(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4,
  parameter int parm_FCLK            = 40_000_000,
  parameter int parm_pwm_period_hz   = 1000,
  parameter int parm_stagger         = 1
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
  input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
  input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
  input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
  output logic [parm_color_led_count-1:0]   o_color_led_red,
  output logic [parm_color_led_count-1:0]   o_color_led_green,
  output logic [parm_color_led_count-1:0]   o_color_led_blue,
  output logic [parm_basic_led_count-1:0]   o_basic_led,
  output logic                              o_period_strobe
);

  localparam int C   = parm_color_led_count;
  localparam int B   = parm_basic_led_count;
  localparam int DIV = parm_FCLK / (parm_pwm_period_hz * 256);
  // Keep the prescaler at least one bit wide. With DIV = 1 it stays at 0,
  // and the tick is then permanently high.
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // Phase offset of LED k within a group of n LEDs. n is a power of two no
  // larger than 8, so k*(256/n) always fits in 8 bits.
  function automatic logic [7:0] led_off(input int k, input int n);
    if (parm_stagger != 0) begin
      return 8'(k * (256 / n));
    end
    return 8'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Timebase: prescaler and PWM counter
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tick;
  logic          boundary;

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
    boundary = tick && (cnt_q == 8'hFF);
  end

  // ---------------------------------------------------------------------------
  // Shadow duties: the inputs are sampled only on the boundary cycle
  // ---------------------------------------------------------------------------
  logic [8*C-1:0] red_sh_q,   red_sh_d;
  logic [8*C-1:0] green_sh_q, green_sh_d;
  logic [8*C-1:0] blue_sh_q,  blue_sh_d;
  logic [8*B-1:0] basic_sh_q, basic_sh_d;
  logic           strobe_q,   strobe_d;

  always_comb begin
    red_sh_d   = boundary ? i_color_led_red_value   : red_sh_q;
    green_sh_d = boundary ? i_color_led_green_value : green_sh_q;
    blue_sh_d  = boundary ? i_color_led_blue_value  : blue_sh_q;
    basic_sh_d = boundary ? i_basic_led_lumin_value : basic_sh_q;
    strobe_d   = boundary;
  end

  // ---------------------------------------------------------------------------
  // Per-LED phase and compare
  // ---------------------------------------------------------------------------
  logic [C-1:0][7:0] col_ph;
  logic [B-1:0][7:0] bas_ph;

  always_comb begin
    col_ph = '0;
    for (int k = 0; k < C; k++) begin
      col_ph[k] = cnt_q + led_off(k, C);
    end
    bas_ph = '0;
    for (int k = 0; k < B; k++) begin
      bas_ph[k] = cnt_q + led_off(k, B);
    end
  end

  logic [C-1:0] red_q,   red_d;
  logic [C-1:0] green_q, green_d;
  logic [C-1:0] blue_q,  blue_d;
  logic [B-1:0] basic_q, basic_d;

  // A strict less-than gives exactly d high phases out of 0..255. Duty 0 is
  // therefore never high, and duty 255 is low only at phase 255.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    for (int k = 0; k < C; k++) begin
      red_d[k]   = col_ph[k] < red_sh_q[8*k +: 8];
      green_d[k] = col_ph[k] < green_sh_q[8*k +: 8];
      blue_d[k]  = col_ph[k] < blue_sh_q[8*k +: 8];
    end
    basic_d = '0;
    for (int k = 0; k < B; k++) begin
      basic_d[k] = bas_ph[k] < basic_sh_q[8*k +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      red_sh_q   <= '0;
      green_sh_q <= '0;
      blue_sh_q  <= '0;
      basic_sh_q <= '0;
      strobe_q   <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      basic_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      red_sh_q   <= red_sh_d;
      green_sh_q <= green_sh_d;
      blue_sh_q  <= blue_sh_d;
      basic_sh_q <= basic_sh_d;
      strobe_q   <= strobe_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      basic_q    <= basic_d;
    end
  end

  assign o_color_led_red   = red_q;
  assign o_color_led_green = green_q;
  assign o_color_led_blue  = blue_q;
  assign o_basic_led       = basic_q;
  assign o_period_strobe   = strobe_q;

endmodule
